// File: rtl/clk_sel_seq.sv
// rtl/clk_sel_seq.sv - N-way break-before-make clock source select sequencer
//
// Ports:
//   clk_i          always-on reference clock; every signal lives in this domain
//   rst_ni         synchronous active-low reset
//   sel_i          requested source index
//   sel_valid_i    request valid; accepted when sel_ready_o is also high
//   sel_ready_o    high only while idle
//   en_ack_i       per-gate enable status, already synchronised into clk_i
//   en_o           per-gate enable, zero or one-hot
//   cur_sel_o      committed (fully switched) source index
//   busy_o         switch in progress
//   done_o         one-cycle pulse when a switch or same-source request completes
//   err_clr_i      clears both sticky error flags (a same-cycle set wins)
//   err_timeout_o  sticky: a gate acknowledge wait expired
//   err_range_o    sticky: a request named a source >= NUM_CLK

module clk_sel_seq #(
    parameter int NUM_CLK        = 4,
    parameter int SEL_W          = $clog2(NUM_CLK),
    parameter int RESET_SEL      = 0,
    parameter int DEAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               sel_valid_i,
    output logic               sel_ready_o,
    input  logic [NUM_CLK-1:0] en_ack_i,
    output logic [NUM_CLK-1:0] en_o,
    output logic [SEL_W-1:0]   cur_sel_o,
    output logic               busy_o,
    output logic               done_o,
    input  logic               err_clr_i,
    output logic               err_timeout_o,
    output logic               err_range_o
);

    // One counter serves both the ack timeout (DISABLE/ENABLE) and the dead
    // time (DEAD); it is cleared on every state entry so the uses never mix.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > DEAD_CYCLES) ? TIMEOUT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0] RESET_SEL_V  = SEL_W'(RESET_SEL);
    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // One bit wider than sel_i so a power-of-two NUM_CLK is representable.
    localparam logic [SEL_W:0]   NUM_CLK_V    = (SEL_W + 1)'(NUM_CLK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISABLE,
        ST_DEAD,
        ST_ENABLE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CLK-1:0] en_q, en_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_range_q, err_range_d;
    logic               timeout_set;
    logic               range_set;

    function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CLK-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cur_sel_d   = cur_sel_q;
        done_d      = 1'b0;
        timeout_set = 1'b0;
        range_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sel_valid_i && ready_q) begin
                    if ({1'b0, sel_i} >= NUM_CLK_V) begin
                        range_set = 1'b1;
                    end else if (sel_i == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = sel_i;
                        state_d  = ST_DISABLE;
                    end
                end
            end
            ST_DISABLE: begin
                // A stuck-on gate still lets the switch proceed after the
                // timeout; the error flag tells software the old gate lied.
                if (!en_ack_i[cur_sel_q]) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_DEAD;
                    cnt_d       = '0;
                end
            end
            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_ENABLE;
                    cnt_d   = '0;
                end
            end
            ST_ENABLE: begin
                if (en_ack_i[target_q] || (cnt_q == TIMEOUT_LAST)) begin
                    timeout_set = !en_ack_i[target_q];
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    cur_sel_d   = target_q;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it; only IDLE and ENABLE ever drive an enable, each one bit.
        en_d    = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            ST_IDLE: begin
                en_d    = onehot(cur_sel_d);
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_ENABLE: begin
                en_d = onehot(target_d);
            end
            default: begin
                en_d = '0;
            end
        endcase

        err_timeout_d = timeout_set | (err_timeout_q & ~err_clr_i);
        err_range_d   = range_set   | (err_range_q   & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_ENABLE;
            target_q      <= RESET_SEL_V;
            cnt_q         <= '0;
            en_q          <= onehot(RESET_SEL_V);
            cur_sel_q     <= RESET_SEL_V;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            cur_sel_q     <= cur_sel_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_range_q   <= err_range_d;
        end
    end

    assign en_o          = en_q;
    assign cur_sel_o     = cur_sel_q;
    assign sel_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_timeout_q;
    assign err_range_o   = err_range_q;

endmodule

// File: tb/tb_clk_sel_seq.sv
// tb/tb_clk_sel_seq.sv - directed-vector bench for clk_sel_seq (4-source and 3-source instances)

module tb_clk_sel_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic [1:0] sel_a;
    logic       sel_valid_a, sel_ready_a;
    logic [3:0] ack_a, en_a, hold_a;
    logic [1:0] cur_a;
    logic       busy_a, done_a, err_clr_a, err_to_a, err_rng_a;

    logic [1:0] sel_b;
    logic       sel_valid_b, sel_ready_b;
    logic [2:0] ack_b, en_b;
    logic [1:0] cur_b;
    logic       busy_b, done_b, err_clr_b, err_to_b, err_rng_b;

    logic       mirror;
    int         vectors     = 0;
    int         miscompares = 0;
    int         onehot_viol = 0;
    int         lat, zc, to_at;

    clk_sel_seq #(.NUM_CLK(4), .RESET_SEL(0), .DEAD_CYCLES(2), .TIMEOUT_CYCLES(64)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel_a), .sel_valid_i(sel_valid_a),
        .sel_ready_o(sel_ready_a), .en_ack_i(ack_a), .en_o(en_a), .cur_sel_o(cur_a),
        .busy_o(busy_a), .done_o(done_a), .err_clr_i(err_clr_a),
        .err_timeout_o(err_to_a), .err_range_o(err_rng_a)
    );

    clk_sel_seq #(.NUM_CLK(3), .RESET_SEL(0), .DEAD_CYCLES(2), .TIMEOUT_CYCLES(64)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel_b), .sel_valid_i(sel_valid_b),
        .sel_ready_o(sel_ready_b), .en_ack_i(ack_b), .en_o(en_b), .cur_sel_o(cur_b),
        .busy_o(busy_b), .done_o(done_b), .err_clr_i(err_clr_b),
        .err_timeout_o(err_to_b), .err_range_o(err_rng_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge. In mirror
    // mode each gate acknowledge follows its enable one cycle late, with
    // hold_a forcing selected acks of instance A stuck high.
    task automatic step();
        logic [3:0] pa;
        logic [2:0] pb;
        pa = en_a;
        pb = en_b;
        @(posedge clk);
        #1;
        if (mirror) begin
            ack_a = pa | hold_a;
            ack_b = pb;
        end
        if ($countones(en_a) > 1 || $countones(en_b) > 1) onehot_viol++;
    endtask

    initial begin
        rst_n = 1'b0; mirror = 1'b0; hold_a = '0;
        sel_a = '0; sel_valid_a = 1'b0; ack_a = '0; err_clr_a = 1'b0;
        sel_b = '0; sel_valid_b = 1'b0; ack_b = '0; err_clr_b = 1'b0;

        // reset state
        step(); step();
        check("rst_en", en_a, 4'b0001);
        check("rst_cur", cur_a, 0);
        check("rst_busy", busy_a, 1);
        check("rst_ready", sel_ready_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err_to", err_to_a, 0);
        check("rst_err_rng", err_rng_a, 0);
        check("rst_en_b", en_b, 3'b001);

        // release, ack for source 0 arrives three cycles later
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_en", en_a, 4'b0001);
            check("rel_busy", busy_a, 1);
        end
        ack_a = 4'b0001;
        step();
        check("rel_done", done_a, 1);
        check("rel_cur", cur_a, 0);
        check("rel_ready", sel_ready_a, 1);
        check("rel_busy_lo", busy_a, 0);
        check("rel_en_hold", en_a, 4'b0001);
        step();
        check("rel_done_lo", done_a, 0);

        // switch 0 -> 2 with acks following enables by one cycle
        mirror = 1'b1;
        sel_a = 2'd2; sel_valid_a = 1'b1;
        step();
        sel_valid_a = 1'b0;
        check("sw_acc_en", en_a, 4'b0000);
        check("sw_acc_busy", busy_a, 1);
        check("sw_acc_ready", sel_ready_a, 0);
        lat = 0; zc = 1;
        for (int i = 2; i <= 20; i++) begin
            step();
            if (en_a == 4'b0000) zc++;
            if (done_a) begin
                lat = i;
                break;
            end
        end
        check("sw_latency", lat, 7);
        check("sw_zero_cycles", zc, 4);
        check("sw_cur", cur_a, 2);
        check("sw_en", en_a, 4'b0100);
        check("sw_busy", busy_a, 0);
        step();
        check("sw_done_lo", done_a, 0);

        // same-source request is a no-op with a done pulse
        sel_a = 2'd2; sel_valid_a = 1'b1;
        step();
        sel_valid_a = 1'b0;
        check("same_done", done_a, 1);
        check("same_busy", busy_a, 0);
        check("same_en", en_a, 4'b0100);
        check("same_cur", cur_a, 2);
        step();
        check("same_done_lo", done_a, 0);
        check("same_en2", en_a, 4'b0100);

        // out-of-range request on the 3-source instance
        sel_b = 2'd3; sel_valid_b = 1'b1;
        step();
        sel_valid_b = 1'b0;
        check("rng_set", err_rng_b, 1);
        check("rng_en", en_b, 3'b001);
        check("rng_cur", cur_b, 0);
        check("rng_ready", sel_ready_b, 1);
        err_clr_b = 1'b1;
        step();
        err_clr_b = 1'b0;
        check("rng_clr", err_rng_b, 0);
        sel_b = 2'd3; sel_valid_b = 1'b1; err_clr_b = 1'b1;
        step();
        sel_valid_b = 1'b0; err_clr_b = 1'b0;
        check("rng_set_wins", err_rng_b, 1);
        err_clr_b = 1'b1;
        step();
        err_clr_b = 1'b0;
        check("rng_clr2", err_rng_b, 0);
        check("rng_no_to", err_to_b, 0);

        // old gate ack stuck high: timeout after 64 DISABLE cycles, switch 2 -> 1 completes
        hold_a = 4'b0100;
        sel_a = 2'd1; sel_valid_a = 1'b1;
        step();
        sel_valid_a = 1'b0;
        check("to_acc_en", en_a, 4'b0000);
        to_at = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (err_to_a) begin
                to_at = i;
                break;
            end
        end
        check("to_cycle", to_at, 64);
        check("to_en_off", en_a, 4'b0000);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_a) begin
                lat = i;
                break;
            end
        end
        check("to_latency", lat, 4);
        check("to_cur", cur_a, 1);
        check("to_en", en_a, 4'b0010);
        check("to_sticky", err_to_a, 1);

        // reset while in DEAD heading to source 3
        hold_a = '0;
        sel_a = 2'd3; sel_valid_a = 1'b1;
        step();
        sel_valid_a = 1'b0;
        step(); step();
        check("dead_en", en_a, 4'b0000);
        rst_n = 1'b0;
        step();
        check("abort_en", en_a, 4'b0001);
        check("abort_cur", cur_a, 0);
        check("abort_busy", busy_a, 1);
        check("abort_ready", sel_ready_a, 0);
        check("abort_done", done_a, 0);
        check("abort_err_to", err_to_a, 0);
        check("abort_err_rng", err_rng_a, 0);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_a) begin
                lat = i;
                break;
            end
        end
        check("abort_latency", lat, 2);
        check("abort_final_cur", cur_a, 0);
        check("abort_final_en", en_a, 4'b0001);

        check("onehot_viol", onehot_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_sel_seq.md
Name: clk_sel_seq

Overview:
- N-way glitch-free clock-selection sequencer for the clock/reset generator.
- Runs entirely in the always-on reference clock domain.
- Drives one-hot per-source gate enables to downstream clock gates, which feed an OR-combine, and observes each gate's synchronised status.
- Guarantees break-before-make: old source confirmed off, then a programmable dead time, then new source enabled. Generalises the 2-input PLL mux to N sources with handshake, timeout and error reporting.

Parameters:
- NUM_CLK, 4: number of selectable clock sources; must be at least 2.
- SEL_W, $clog2(NUM_CLK): width of the select field (derived).
- RESET_SEL, 0: source enabled out of reset; must be less than NUM_CLK.
- DEAD_CYCLES, 2: cycles with all enables low between off-ack and the new enable; must be at least 1.
- TIMEOUT_CYCLES, 64: maximum wait for a gate acknowledge before flagging an error.

Ports:
- clk_i, input, 1: always-on reference clock.
- rst_ni, input, 1: synchronous, active-low reset.
- sel_i, input, SEL_W: requested source index.
- sel_valid_i, input, 1: request valid.
- sel_ready_o, output, 1: sequencer can accept a request.
- en_ack_i, input, NUM_CLK: per-gate enable status, already synchronised into clk_i.
- en_o, output, NUM_CLK: per-gate enable; zero or one-hot.
- cur_sel_o, output, SEL_W: committed (fully switched) source index.
- busy_o, output, 1: switch in progress.
- done_o, output, 1: one-cycle pulse on switch completion.
- err_clr_i, input, 1: clears the sticky error flags.
- err_timeout_o, output, 1: sticky flag; an acknowledge wait expired.
- err_range_o, output, 1: sticky flag; a request had sel_i >= NUM_CLK.

Behaviour:
- All outputs are registered. Reset is synchronous: acts on a clk_i edge while rst_ni is 0.
- Reset values:
  - state = ENABLE, target = RESET_SEL.
  - en_o = 1<<RESET_SEL.
  - cur_sel_o = RESET_SEL.
  - sel_ready_o = 0, busy_o = 1, done_o = 0.
  - Both error flags = 0; timeout counter = 0.
- States:
  - IDLE: en_o = 1<<cur_sel_o, sel_ready_o = 1, busy_o = 0.
  - DISABLE: en_o = 0. Wait for en_ack_i[cur_sel_o] == 0.
  - DEAD: en_o = 0. Count DEAD_CYCLES cycles.
  - ENABLE: en_o = 1<<target. Wait for en_ack_i[target] == 1.
- Handshake: a request is accepted on a cycle where sel_valid_i && sel_ready_o. sel_ready_o is 1 only in IDLE.
- Request handling:
  - Accepted with sel_i >= NUM_CLK: stay in IDLE, set err_range_o next cycle, en_o unchanged.
  - Accepted with sel_i == cur_sel_o: no-op; stay in IDLE; done_o pulses next cycle.
  - Otherwise: latch target = sel_i, go to DISABLE. en_o is all-zero on the cycle after acceptance.
- DISABLE → DEAD: on the cycle en_ack_i[cur_sel_o] is sampled 0.
- DEAD → ENABLE: after exactly DEAD_CYCLES cycles in DEAD.
- ENABLE → IDLE: on the cycle en_ack_i[target] is sampled 1. On that transition cur_sel_o = target and done_o = 1 for one cycle.
- Minimum latency from acceptance to done_o is DEAD_CYCLES+3 cycles, with acks returning immediately.
- Timeout counter:
  - Clears on every state entry and counts while in DISABLE or ENABLE.
  - If the awaited ack has not arrived after TIMEOUT_CYCLES cycles in the state, set err_timeout_o.
  - In DISABLE: force the transition to DEAD.
  - In ENABLE: go to IDLE with cur_sel_o = target and pulse done_o. en_o stays asserted.
- en_o never has more than one bit set on any cycle, including reset and timeout paths.
- Error flags:
  - err_clr_i clears both flags.
  - If a set event and err_clr_i occur on the same cycle, set wins.
- Reset asserted mid-switch: abort immediately to the reset values; the target is discarded.
- sel_valid_i while not ready: ignored; the requester must hold it until accepted.

Test Plan:
- Reset release with RESET_SEL=0 and en_ack_i[0] rising 3 cycles later → en_o=4'b0001 throughout; busy_o=1 until ack; then done_o pulse, cur_sel_o=0, sel_ready_o=1.
- From IDLE sel 0, request sel_i=2 with acks mirroring en_o after 1 cycle → en_o 0001 → 0000 for ≥ DEAD_CYCLES+1 cycles → 0100; done_o pulse; cur_sel_o=2; en_o never has two bits set.
- Request sel_i=cur_sel_o=2 → no change in en_o; done_o pulses the cycle after acceptance; busy_o stays 0.
- NUM_CLK=3, request sel_i=3 → err_range_o=1 next cycle, en_o unchanged; err_clr_i pulse → flag 0.
- Hold en_ack_i[old]=1 forever during a switch → after 64 DISABLE cycles err_timeout_o=1, switch proceeds, new source enabled, done_o pulses.
- Assert rst_ni=0 while in DEAD heading to source 3 → next edge: en_o=0001, cur_sel_o=0, busy_o=1, error flags 0.
